// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-sequencing controller for the WISC-S15 pipeline.
// Owns the architectural fetch PC and arbitrates the next-PC source each cycle
// (return > taken branch/call > stall > halt > increment), and drives the
// IF/ID write enable plus the IF/ID and ID/EX flush strobes after a redirect.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic        upd_valid,
    input  logic        upd_src,
    input  logic [15:0] upd_pc,
    input  logic        ret_valid,
    input  logic [15:0] ret_pc,
    input  logic        halt,
    output logic [15:0] pc,
    output logic        fetch_en,
    output logic        if_id_we,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        halted,
    output logic [7:0]  redirect_count
);

    typedef enum logic [2:0] {
        INIT,
        RUN,
        STALL,
        FLUSH,
        HALT
    } state_t;

    // Remaining FLUSH cycles are counted down from FLUSH_DEPTH-1 to 1.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    state_t      state;
    logic [2:0]  flush_cnt;

    logic        arb_active;
    logic        take_ret;
    logic        take_upd;
    logic        redirect;
    logic        do_stall;
    logic        do_halt;
    logic [15:0] redirect_pc;

    // Only RUN and STALL look at the pipeline's event inputs; INIT, FLUSH and
    // HALT never let inputs reach the outputs or the next state.
    assign arb_active  = (state == RUN) || (state == STALL);
    assign take_ret    = arb_active & ret_valid;
    assign take_upd    = arb_active & ~ret_valid & upd_valid & upd_src;
    assign redirect    = take_ret | take_upd;
    assign do_stall    = arb_active & ~redirect & stall_req;
    assign do_halt     = arb_active & ~redirect & ~stall_req & halt;
    assign redirect_pc = take_ret ? ret_pc : upd_pc;

    // Control strobes: Mealy in RUN/STALL, pure functions of state elsewhere.
    always_comb begin
        fetch_en    = 1'b0;
        if_id_we    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN, STALL: begin
                if (redirect) begin
                    fetch_en    = 1'b1;
                    if_id_we    = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (do_stall) begin
                    fetch_en    = 1'b1;
                end else if (do_halt) begin
                    fetch_en    = 1'b0;
                end else begin
                    fetch_en    = 1'b1;
                    if_id_we    = 1'b1;
                end
            end
            FLUSH: begin
                fetch_en    = 1'b1;
                if_id_we    = 1'b1;
                flush_id_ex = 1'b1;
            end
            HALT: begin
                halted      = 1'b1;
            end
            default: begin
                fetch_en    = 1'b0;
            end
        endcase
    end

    // Sequencer: fetch PC, state, flush countdown and redirect counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            pc             <= RESET_PC;
            flush_cnt      <= '0;
            redirect_count <= '0;
        end else begin
            case (state)
                INIT: begin
                    state <= RUN;
                end
                RUN, STALL: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (redirect_count != 8'hFF) begin
                            redirect_count <= redirect_count + 8'd1;
                        end
                        if (FLUSH_DEPTH == 1) begin
                            state <= RUN;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end
                    end else if (do_stall) begin
                        state <= STALL;
                    end else if (do_halt) begin
                        state <= HALT;
                    end else begin
                        pc    <= pc + 16'd1;
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    pc <= pc + 16'd1;
                    if (flush_cnt <= 3'd1) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed vectors with hand-computed expected
// outputs pushed into a scoreboard queue, checked by an independent monitor.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall_req;
    logic        upd_valid;
    logic        upd_src;
    logic [15:0] upd_pc;
    logic        ret_valid;
    logic [15:0] ret_pc;
    logic        halt;
    logic [15:0] pc;
    logic        fetch_en;
    logic        if_id_we;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic [7:0]  redirect_count;

    // Control-field order: {fetch_en, if_id_we, flush_if_id, flush_id_ex, halted}
    localparam logic [4:0] C_OFF   = 5'b00000;
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b10000;
    localparam logic [4:0] C_REDIR = 5'b11110;
    localparam logic [4:0] C_FLUSH = 5'b11010;
    localparam logic [4:0] C_HALT  = 5'b00001;

    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  ctl;
        logic [7:0]  rc;
        logic        chk_ctl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec;
    int    n_miss;

    pc_fetch_ctrl #(
        .RESET_PC   (16'h0000),
        .FLUSH_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_req     (stall_req),
        .upd_valid     (upd_valid),
        .upd_src       (upd_src),
        .upd_pc        (upd_pc),
        .ret_valid     (ret_valid),
        .ret_pc        (ret_pc),
        .halt          (halt),
        .pc            (pc),
        .fetch_en      (fetch_en),
        .if_id_we      (if_id_we),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .halted        (halted),
        .redirect_count(redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples on the falling edge and checks against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [4:0]  act_ctl;
            logic        bad;
            e       = exp_q.pop_front();
            nm      = name_q.pop_front();
            act_ctl = {fetch_en, if_id_we, flush_if_id, flush_id_ex, halted};
            bad     = (pc !== e.pc) || (redirect_count !== e.rc) ||
                      (e.chk_ctl && (act_ctl !== e.ctl));
            n_vec++;
            if (bad) begin
                n_miss++;
                $display("FAIL %s: got pc=%h ctl=%b rc=%h, expected pc=%h ctl=%b rc=%h%s",
                         nm, pc, act_ctl, redirect_count, e.pc, e.ctl, e.rc,
                         e.chk_ctl ? "" : " (ctl not checked)");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        stall_req = 1'b0;
        upd_valid = 1'b0;
        upd_src   = 1'b0;
        upd_pc    = 16'h0000;
        ret_valid = 1'b0;
        ret_pc    = 16'h0000;
        halt      = 1'b0;
    endtask

    task automatic taken(input logic [15:0] tgt);
        upd_valid = 1'b1;
        upd_src   = 1'b1;
        upd_pc    = tgt;
    endtask

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic step(input logic [15:0] p, input logic [4:0] ctl,
                        input logic [7:0] rc, input string nm, input logic chk);
        exp_t e;
        e.pc      = p;
        e.ctl     = ctl;
        e.rc      = rc;
        e.chk_ctl = chk;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] t;
        logic [7:0]  cur;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step(16'h0000, C_OFF, 8'h00, "reset", 1'b1);
        step(16'h0000, C_OFF, 8'h00, "reset", 1'b1);

        // Release reset: one INIT cycle, then free-run from RESET_PC.
        rst_n = 1'b1;
        step(16'h0000, C_OFF, 8'h00, "init", 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(16'(i), C_RUN, 8'h00, "run", 1'b1);
        end

        // Taken branch at 0x0010 to 0x0100.
        taken(16'h0100);
        step(16'h0010, C_REDIR, 8'h00, "br_redir", 1'b1);
        idle();
        step(16'h0100, C_FLUSH, 8'h01, "br_flush", 1'b1);
        step(16'h0101, C_RUN,   8'h01, "br_run", 1'b1);
        step(16'h0102, C_RUN,   8'h01, "br_run", 1'b1);

        // Not-taken branch is no event.
        upd_valid = 1'b1;
        upd_src   = 1'b0;
        upd_pc    = 16'h0200;
        step(16'h0103, C_RUN, 8'h01, "not_taken", 1'b1);
        idle();
        step(16'h0104, C_RUN, 8'h01, "not_taken_next", 1'b1);

        // Return beats a simultaneous taken branch.
        taken(16'h0100);
        ret_valid = 1'b1;
        ret_pc    = 16'h0040;
        step(16'h0105, C_REDIR, 8'h01, "ret_prio_redir", 1'b1);
        idle();
        step(16'h0040, C_FLUSH, 8'h02, "ret_prio_flush", 1'b1);
        step(16'h0041, C_RUN,   8'h02, "ret_prio_run", 1'b1);

        // Move to 0x0004 so RUN reaches 0x0005 for the stall test.
        taken(16'h0004);
        step(16'h0042, C_REDIR, 8'h02, "to4_redir", 1'b1);
        idle();
        step(16'h0004, C_FLUSH, 8'h03, "to4_flush", 1'b1);

        // Three-cycle stall at 0x0005.
        stall_req = 1'b1;
        step(16'h0005, C_STALL, 8'h03, "stall", 1'b1);
        step(16'h0005, C_STALL, 8'h03, "stall", 1'b1);
        step(16'h0005, C_STALL, 8'h03, "stall", 1'b1);
        idle();
        step(16'h0005, C_RUN, 8'h03, "stall_exit", 1'b1);
        step(16'h0006, C_RUN, 8'h03, "stall_resume", 1'b1);

        // Taken branch during a stall redirects at once.
        stall_req = 1'b1;
        step(16'h0007, C_STALL, 8'h03, "stall2", 1'b1);
        taken(16'h0300);
        step(16'h0007, C_REDIR, 8'h03, "stall_br_redir", 1'b1);
        idle();
        step(16'h0300, C_FLUSH, 8'h04, "stall_br_flush", 1'b1);
        step(16'h0301, C_RUN,   8'h04, "stall_br_run", 1'b1);

        // Events during FLUSH are ignored.
        taken(16'h0500);
        step(16'h0302, C_REDIR, 8'h04, "fl_ign_redir", 1'b1);
        taken(16'h0900);
        stall_req = 1'b1;
        step(16'h0500, C_FLUSH, 8'h05, "fl_ign_flush", 1'b1);
        idle();
        step(16'h0501, C_RUN, 8'h05, "fl_ign_run", 1'b1);

        // Halt: sticky, pc frozen, all inputs ignored.
        halt = 1'b1;
        step(16'h0502, C_OFF, 8'h05, "halt_entry", 1'b0);
        step(16'h0502, C_HALT, 8'h05, "halted", 1'b1);
        idle();
        taken(16'h0700);
        ret_valid = 1'b1;
        ret_pc    = 16'h0800;
        step(16'h0502, C_HALT, 8'h05, "halted_ign", 1'b1);
        idle();
        stall_req = 1'b1;
        step(16'h0502, C_HALT, 8'h05, "halted_ign", 1'b1);
        idle();

        // Asynchronous reset mid-HALT.
        rst_n = 1'b0;
        step(16'h0000, C_OFF, 8'h00, "rst_halt", 1'b1);
        rst_n = 1'b1;
        step(16'h0000, C_OFF, 8'h00, "init2", 1'b1);
        step(16'h0000, C_RUN, 8'h00, "run2", 1'b1);
        step(16'h0001, C_RUN, 8'h00, "run2", 1'b1);

        // PC wrap at 0xFFFF.
        taken(16'hFFFF);
        step(16'h0002, C_REDIR, 8'h00, "wrap_redir", 1'b1);
        idle();
        step(16'hFFFF, C_FLUSH, 8'h01, "wrap_flush", 1'b1);
        step(16'h0000, C_RUN,   8'h01, "wrap", 1'b1);
        step(16'h0001, C_RUN,   8'h01, "wrap_run", 1'b1);

        // 300 back-to-back redirects saturate the counter.
        p   = 16'h0002;
        cur = 8'h01;
        for (int k = 0; k < 300; k++) begin
            t = 16'(16'h2000 + k);
            taken(t);
            step(p, C_REDIR, cur, "sat_redir", 1'b1);
            idle();
            cur = (cur == 8'hFF) ? 8'hFF : cur + 8'd1;
            step(t, C_FLUSH, cur, "sat_flush", 1'b1);
            p = t + 16'd1;
        end
        step(p, C_RUN, 8'hFF, "sat", 1'b1);
        p = p + 16'd1;

        // Asynchronous reset mid-FLUSH.
        taken(16'h0AAA);
        step(p, C_REDIR, 8'hFF, "sat_last_redir", 1'b1);
        idle();
        rst_n = 1'b0;
        step(16'h0000, C_OFF, 8'h00, "rst_flush", 1'b1);
        rst_n = 1'b1;
        step(16'h0000, C_OFF, 8'h00, "init3", 1'b1);
        step(16'h0000, C_RUN, 8'h00, "run3", 1'b1);

        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d unchecked vectors, expected 0", exp_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-sequencing controller for the WISC-S15 pipeline. Owns the architectural fetch PC register. Each cycle it selects one next-PC source, in priority order: return target (MEM/WB), branch/call target (PC_Update), hazard stall, halt, or sequential increment. It drives the IF/ID write enable and the IF/ID and ID/EX flush strobes that squash wrong-path instructions after a redirect.

## Interface
- RESET_PC, 16'h0000, fetch PC loaded on reset
- FLUSH_DEPTH, 2, cycles of ID/EX flush per redirect; legal range 1–7

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_req  in  1  load-use hazard from hazard unit; hold PC and IF/ID
- upd_valid  in  1  PC_Update update_done; branch/call resolved this cycle
- upd_src  in  1  PC_Update PC_src; 1 = take upd_pc, 0 = not taken
- upd_pc  in  16  PC_Update PC_update target
- ret_valid  in  1  ret retiring in MEM/WB
- ret_pc  in  16  popped return address from MEM/WB
- halt  in  1  HLT decoded in ID
- pc  out  16  current fetch address (word address)
- fetch_en  out  1  instruction memory read enable
- if_id_we  out  1  IF/ID pipeline register write enable
- flush_if_id  out  1  clear IF/ID to NOP
- flush_id_ex  out  1  clear ID/EX to NOP
- halted  out  1  core halted
- redirect_count  out  8  saturating count of accepted redirects

## Operation
- States: INIT, RUN, STALL, FLUSH, HALT.
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, state=INIT, redirect_count=0.
  - All other outputs 0.
- INIT: outputs all 0. Next state RUN unconditionally.
- RUN/STALL arbitration. First match wins:
  1. ret_valid: pc<=ret_pc; redirect.
  2. upd_valid & upd_src: pc<=upd_pc; redirect.
  3. stall_req: pc holds; if_id_we=0; fetch_en=1; state STALL.
  4. halt: pc holds; go to HALT.
  5. Otherwise: pc<=pc+1; if_id_we=1; state RUN.
- upd_valid & !upd_src is a not-taken branch. Treat it as no event.
- Redirect cycle (Mealy outputs):
  - flush_if_id=1, flush_id_ex=1, if_id_we=1, fetch_en=1.
  - redirect_count increments, saturating at 8'hFF.
  - If FLUSH_DEPTH=1, next state RUN; otherwise FLUSH with counter=FLUSH_DEPTH-1.
- FLUSH:
  - Outputs: flush_id_ex=1, flush_if_id=0, if_id_we=1, fetch_en=1; pc<=pc+1.
  - upd_valid, ret_valid, stall_req and halt are ignored; they come from squashed instructions.
  - Counter decrements each cycle. When it reaches 1, next state RUN.
- STALL: same arbitration as RUN. A redirect breaks the stall. Leaving STALL with no event resumes increment.
- HALT:
  - fetch_en=0, if_id_we=0, halted=1; pc frozen; all inputs ignored.
  - Sticky until rst_n is asserted.
- PC arithmetic is 16-bit unsigned. 16'hFFFF+1 wraps to 16'h0000.

## Timing
- pc, state, counter and redirect_count are registered on the clk rising edge.
- fetch_en, if_id_we, flush_* and halted are combinational from state and current inputs. There are no input-to-output paths in INIT, FLUSH or HALT.
- Redirect latency: target request in cycle N; pc shows the target after edge N+1; the target's first fetch is in cycle N+1.
- Stall latency is zero: if_id_we drops in the same cycle stall_req is asserted.
- rst_n assertion mid-FLUSH or mid-HALT returns to INIT immediately, without waiting for a clock.
- The first fetch of RESET_PC occurs one cycle after rst_n deasserts (the INIT cycle).

## Test plan
- Reset then free-run, RESET_PC=16'h0000:
  - INIT cycle shows fetch_en=0.
  - Then pc runs 0,1,2,3 with if_id_we=1 and no flushes.
- Taken branch: at pc=16'h0010, drive upd_valid=1, upd_src=1, upd_pc=16'h0100.
  - Same cycle: flush_if_id=flush_id_ex=1.
  - Next cycle: pc=16'h0100, flush_id_ex=1 only.
  - Then RUN; redirect_count=1.
- Simultaneous ret_valid (ret_pc=16'h0040) and taken branch (upd_pc=16'h0100): pc goes to 16'h0040.
- Stall for 3 cycles at pc=16'h0005:
  - pc holds 16'h0005; if_id_we=0 for exactly 3 cycles.
  - Then 16'h0006.
  - A taken branch during the stall redirects at once.
- During FLUSH, pulse upd_valid/upd_src and stall_req: both ignored and pc increments. Then assert halt: fetch_en=0, halted=1, pc frozen until rst_n.
- Wrap and saturation:
  - Start at pc=16'hFFFF; next pc is 16'h0000.
  - 300 redirects leave redirect_count=8'hFF.
  - rst_n pulsed mid-FLUSH asynchronously restores pc=RESET_PC and redirect_count=0.
